inst_mem_port_arbiter: RTL and testbench
========================================

// Module: inst_mem_port_arbiter
// PURPOSE
//  - Shares the single-port instruction SRAM between two requesters:
//    - port C: core instruction fetch (req/gnt/rvalid, read-only).
//    - port B: AXI-side bus bridge (read/write, used for program load and debug).
//  - Sits inside core_instruction_top, between the fetch interface / AXI-to-mem bridge and the SRAM macro.
//  - Decodes the instruction-memory window; misses get an error response.
// PARAMETERS
//  INST_MEM_SIZE_IN_KB  8              SRAM size; MEM_AW = $clog2(INST_MEM_SIZE_IN_KB*256) word-address bits
//  MEM_BASE_ADDR        32'h2000_0000  byte base of the window; must be aligned to the window size
//  STARVE_LIMIT         4              consecutive lost conflicts before port B is forced to win (fairness only)
// PORTS
//  clk_i          in   1       clock
//  reset_ni       in   1       synchronous, active-low reset
//  core_req_i     in   1       core fetch request
//  core_addr_i    in   32      core byte address, word aligned
//  core_gnt_o     out  1       core request accepted this cycle
//  core_rvalid_o  out  1       core response valid
//  core_rdata_o   out  32      core read data
//  core_err_o     out  1       core response error (address outside window)
//  bus_req_i      in   1       bus request
//  bus_we_i       in   1       bus write enable
//  bus_addr_i     in   32      bus byte address, word aligned
//  bus_wdata_i    in   32      bus write data
//  bus_be_i       in   4       bus byte enables
//  bus_gnt_o      out  1       bus request accepted this cycle
//  bus_rvalid_o   out  1       bus response valid (pulsed for reads and writes)
//  bus_rdata_o    out  32      bus read data (0 for writes)
//  bus_err_o      out  1       bus response error
//  mem_req_o      out  1       SRAM access strobe
//  mem_we_o       out  1       SRAM write enable
//  mem_addr_o     out  MEM_AW  SRAM word address = addr[MEM_AW+1:2]
//  mem_wdata_o    out  32      SRAM write data
//  mem_be_o       out  4       SRAM byte enables
//  mem_rdata_i    in   32      SRAM read data, valid 1 cycle after mem_req_o
// BEHAVIOUR
//  - Reset (reset_ni=0 at posedge):
//    - all registered outputs and state clear to 0 (rvalid/err/rdata, owner, miss flag, starve counter).
//    - any response pending at reset is dropped, never delivered.
//  - Grant (combinational, same cycle as req, at most one of core_gnt_o/bus_gnt_o high):
//    - only one requester: it is granted.
//    - both requesting: core wins, except when fairness forces port B (see CONFIGURATION).
//  - Address decode: hit = (addr & ~(SIZE-1)) == MEM_BASE_ADDR, with SIZE = INST_MEM_SIZE_IN_KB*1024.
//    - granted hit: mem_req_o=1 that cycle; mem_we_o = bus_we_i for port B, 0 for port C.
//    - granted miss: still granted, but mem_req_o=0 and no write occurs.
//    - mem_req_o=0 whenever nothing is granted; mem_* data/address outputs are don't-care then.
//  - Response: exactly 1 cycle after a grant, to the requester granted in that cycle.
//    - State: registered owner (C/B), valid flag and miss flag.
//    - Hit read: rvalid=1, rdata=mem_rdata_i, err=0.
//    - Bus write: rvalid=1, rdata=0, err=0.
//    - Miss: rvalid=1, err=1, rdata=0.
//    - Non-owner port: rvalid=0, rdata=0.
//  - Back-to-back grants every cycle are legal. A port may get a grant in the same cycle it receives
//    its previous response. No other buffering.
//  - Losing requester holds req/addr/data stable until granted; no timeout.
// CONFIGURATION
//  - INST_ARB_FAIRNESS_EN defined:
//    - 3-bit saturating starve_cnt; +1 each cycle both request and core wins.
//    - cleared on any bus grant and when bus_req_i=0.
//    - when starve_cnt == STARVE_LIMIT and both request: port B wins that cycle.
//  - Not defined: strict core priority; port B may starve indefinitely; no counter logic generated.
// TESTING
//  1. Reset: hold reset_ni=0 with both req=1 -> all response outputs 0. Release -> grants resume on the next cycle.
//  2. Core read 0x2000_0020, SRAM word 8 = 0xDEAD_BEEF -> core_gnt_o same cycle, mem_addr_o=8,
//     core_rvalid_o=1 next cycle with rdata 0xDEAD_BEEF, err=0.
//  3. Core read 0x3000_0010 -> granted, mem_req_o=0; next cycle core_rvalid_o=1, core_err_o=1, rdata=0.
//  4. Bus write 0x2000_0004 data 0x1234_5678 be=4'b0011, then core read of same address
//     -> SRAM sees we=1 be=3; bus_rvalid_o pulse; core reads 0x????_5678 bytes updated.
//  5. Both req held 10 cycles with fairness on, STARVE_LIMIT=4 -> core granted 4 cycles,
//     bus on cycle 5, then core 4, bus 1. With macro off: core granted all 10, bus 0.
//  6. Core grant at cycle N, assert reset_ni=0 at cycle N+1 edge -> no core_rvalid_o ever delivered for that request.

Source files
------------

// File: rtl/inst_mem_port_arbiter.sv
// inst_mem_port_arbiter
// Shares the single-port instruction SRAM between the core fetch port (C)
// and the AXI bridge port (B). Decodes the instruction-memory window and
// answers out-of-window accesses with an error response one cycle later.
// Optional feature macro: INST_ARB_FAIRNESS_EN. When it is defined, a
// starvation counter lets port B win after STARVE_LIMIT lost conflicts.
// When it is undefined, the core always has priority.

module inst_mem_port_arbiter #(
   parameter int          INST_MEM_SIZE_IN_KB = 8,
   parameter logic [31:0] MEM_BASE_ADDR       = 32'h2000_0000,
   parameter int          STARVE_LIMIT        = 4,
   localparam int         MEM_AW              = $clog2(INST_MEM_SIZE_IN_KB * 256)
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              core_req_i,
   input  logic [31:0]       core_addr_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [31:0]       core_rdata_o,
   output logic              core_err_o,
   input  logic              bus_req_i,
   input  logic              bus_we_i,
   input  logic [31:0]       bus_addr_i,
   input  logic [31:0]       bus_wdata_i,
   input  logic [3:0]        bus_be_i,
   output logic              bus_gnt_o,
   output logic              bus_rvalid_o,
   output logic [31:0]       bus_rdata_o,
   output logic              bus_err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic [31:0]       mem_rdata_i
);

   localparam logic [31:0] WIN_SIZE = 32'(INST_MEM_SIZE_IN_KB * 1024);
   localparam logic [31:0] WIN_MASK = ~(WIN_SIZE - 32'd1);

   typedef enum logic {
      OWNER_CORE = 1'b0,
      OWNER_BUS  = 1'b1
   } owner_e;

   logic   coreHit, busHit;
   logic   coreGnt, busGnt;
   logic   forceBus;

   logic   rspValid_q, rspValid_d;
   owner_e rspOwner_q, rspOwner_d;
   logic   rspMiss_q, rspMiss_d;
   logic   rspWrite_q, rspWrite_d;

   logic   coreRsp, busRsp;

`ifdef INST_ARB_FAIRNESS_EN
   logic [2:0] starveCnt_q, starveCnt_d;

   // Port B is forced through once it has lost STARVE_LIMIT conflicts in a row
   assign forceBus = (starveCnt_q == 3'(STARVE_LIMIT));

   // Count lost conflicts; any bus grant or a dropped bus request restarts the count
   always_comb begin
      starveCnt_d = starveCnt_q;
      if (!bus_req_i || busGnt) begin
         starveCnt_d = 3'd0;
      end else if (core_req_i && starveCnt_q != 3'd7) begin
         starveCnt_d = starveCnt_q + 3'd1;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         starveCnt_q <= 3'd0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end
`else
   assign forceBus = 1'b0;
`endif

   // Window decode and same-cycle grant; the core wins unless port B is forced
   always_comb begin
      coreHit = ((core_addr_i & WIN_MASK) == MEM_BASE_ADDR);
      busHit  = ((bus_addr_i & WIN_MASK) == MEM_BASE_ADDR);
      coreGnt = core_req_i && !(bus_req_i && forceBus);
      busGnt  = bus_req_i && (!core_req_i || forceBus);
   end

   assign core_gnt_o = coreGnt;
   assign bus_gnt_o  = busGnt;

   // Drive the SRAM from the granted port; a miss is granted but never touches memory
   always_comb begin
      mem_req_o   = (coreGnt && coreHit) || (busGnt && busHit);
      mem_we_o    = busGnt && busHit && bus_we_i;
      mem_addr_o  = busGnt ? bus_addr_i[MEM_AW+1:2] : core_addr_i[MEM_AW+1:2];
      mem_wdata_o = bus_wdata_i;
      mem_be_o    = busGnt ? bus_be_i : 4'hF;
   end

   // Remember who was granted this cycle so the response goes to them next cycle
   always_comb begin
      rspValid_d = coreGnt || busGnt;
      rspOwner_d = busGnt ? OWNER_BUS : OWNER_CORE;
      rspMiss_d  = busGnt ? !busHit : !coreHit;
      rspWrite_d = busGnt && bus_we_i;
   end

   // Response tracking registers; reset drops any pending response
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         rspValid_q <= 1'b0;
         rspOwner_q <= OWNER_CORE;
         rspMiss_q  <= 1'b0;
         rspWrite_q <= 1'b0;
      end else begin
         rspValid_q <= rspValid_d;
         rspOwner_q <= rspOwner_d;
         rspMiss_q  <= rspMiss_d;
         rspWrite_q <= rspWrite_d;
      end
   end

   // Route the response; read data only passes through for hit reads
   always_comb begin
      coreRsp       = rspValid_q && (rspOwner_q == OWNER_CORE);
      busRsp        = rspValid_q && (rspOwner_q == OWNER_BUS);
      core_rvalid_o = coreRsp;
      core_err_o    = coreRsp && rspMiss_q;
      core_rdata_o  = (coreRsp && !rspMiss_q) ? mem_rdata_i : 32'd0;
      bus_rvalid_o  = busRsp;
      bus_err_o     = busRsp && rspMiss_q;
      bus_rdata_o   = (busRsp && !rspMiss_q && !rspWrite_q) ? mem_rdata_i : 32'd0;
   end

endmodule

// File: tb/tb_inst_mem_port_arbiter.sv
// tb_inst_mem_port_arbiter
// Directed bench for inst_mem_port_arbiter with a behavioural SRAM.
// Expected grant pattern under contention depends on INST_ARB_FAIRNESS_EN.

module tb_inst_mem_port_arbiter;

   localparam int AW = 11;

   logic          clk;
   logic          reset_ni;
   logic          core_req_i;
   logic [31:0]   core_addr_i;
   logic          core_gnt_o, core_rvalid_o, core_err_o;
   logic [31:0]   core_rdata_o;
   logic          bus_req_i, bus_we_i;
   logic [31:0]   bus_addr_i, bus_wdata_i;
   logic [3:0]    bus_be_i;
   logic          bus_gnt_o, bus_rvalid_o, bus_err_o;
   logic [31:0]   bus_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [3:0]    mem_be_o;
   logic [31:0]   mem_rdata_i;

   int checks = 0;
   int errors = 0;

   inst_mem_port_arbiter dut (
      .clk_i(clk), .reset_ni(reset_ni),
      .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_gnt_o(core_gnt_o),
      .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
      .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
      .bus_wdata_i(bus_wdata_i), .bus_be_i(bus_be_i), .bus_gnt_o(bus_gnt_o),
      .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o), .bus_err_o(bus_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM: unwritten words hold a fixed address-derived pattern
   bit [31:0] sram [2048];
   bit        written [2048];

   function automatic logic [31:0] initWord(input int a);
      if (a == 8) return 32'hDEAD_BEEF;
      if (a == 1) return 32'hAABB_CCDD;
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   always @(posedge clk) begin
      if (mem_req_o) begin
         if (mem_we_o) begin
            logic [31:0] w;
            w = written[mem_addr_o] ? sram[mem_addr_o] : initWord(int'(mem_addr_o));
            for (int b = 0; b < 4; b++) begin
               if (mem_be_o[b]) w[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
            end
            sram[mem_addr_o]    <= w;
            written[mem_addr_o] <= 1'b1;
         end
         mem_rdata_i <= written[mem_addr_o] ? sram[mem_addr_o] : initWord(int'(mem_addr_o));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      core_req_i = 1'b0;
      bus_req_i  = 1'b0;
      bus_we_i   = 1'b0;
   endtask

   task automatic test_reset();
      reset_ni    = 1'b0;
      core_req_i  = 1'b1;
      core_addr_i = 32'h2000_0020;
      bus_req_i   = 1'b1;
      bus_we_i    = 1'b0;
      bus_addr_i  = 32'h2000_0004;
      bus_wdata_i = 32'd0;
      bus_be_i    = 4'hF;
      repeat (3) tick();
      checks++;
      if (core_rvalid_o !== 1'b0 || core_err_o !== 1'b0 || core_rdata_o !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_core_rsp actual rvalid=%b err=%b rdata=%h required 0/0/0",
                  core_rvalid_o, core_err_o, core_rdata_o);
      end
      checks++;
      if (bus_rvalid_o !== 1'b0 || bus_err_o !== 1'b0 || bus_rdata_o !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_bus_rsp actual rvalid=%b err=%b rdata=%h required 0/0/0",
                  bus_rvalid_o, bus_err_o, bus_rdata_o);
      end
      reset_ni = 1'b1;
      #1;
      checks++;
      if (core_gnt_o !== 1'b1 || bus_gnt_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release_gnt actual core=%b bus=%b required core=1 bus=0",
                  core_gnt_o, bus_gnt_o);
      end
      tick();
      idle();
      #1;
      checks++;
      if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'hDEAD_BEEF || bus_rvalid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release_rsp actual rvalid=%b rdata=%h busrv=%b required 1/deadbeef/0",
                  core_rvalid_o, core_rdata_o, bus_rvalid_o);
      end
      tick();
   endtask

   task automatic test_core_read();
      core_req_i  = 1'b1;
      core_addr_i = 32'h2000_0020;
      #1;
      checks++;
      if (core_gnt_o !== 1'b1 || bus_gnt_o !== 1'b0 || mem_req_o !== 1'b1 ||
          mem_we_o !== 1'b0 || mem_addr_o !== 11'd8) begin
         errors++;
         $display("[TB] FAIL core_read_req actual gnt=%b bgnt=%b mreq=%b mwe=%b maddr=%0d required 1/0/1/0/8",
                  core_gnt_o, bus_gnt_o, mem_req_o, mem_we_o, mem_addr_o);
      end
      tick();
      idle();
      #1;
      checks++;
      if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'hDEAD_BEEF || core_err_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL core_read_rsp actual rvalid=%b rdata=%h err=%b required 1/deadbeef/0",
                  core_rvalid_o, core_rdata_o, core_err_o);
      end
      tick();
      checks++;
      if (core_rvalid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL core_read_single_pulse actual rvalid=%b required 0", core_rvalid_o);
      end
   endtask

   task automatic test_miss();
      core_req_i  = 1'b1;
      core_addr_i = 32'h3000_0010;
      #1;
      checks++;
      if (core_gnt_o !== 1'b1 || mem_req_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL core_miss_req actual gnt=%b mreq=%b required 1/0", core_gnt_o, mem_req_o);
      end
      tick();
      idle();
      #1;
      checks++;
      if (core_rvalid_o !== 1'b1 || core_err_o !== 1'b1 || core_rdata_o !== 32'd0) begin
         errors++;
         $display("[TB] FAIL core_miss_rsp actual rvalid=%b err=%b rdata=%h required 1/1/0",
                  core_rvalid_o, core_err_o, core_rdata_o);
      end
      // Bus write just above the window must not reach the SRAM
      bus_req_i   = 1'b1;
      bus_we_i    = 1'b1;
      bus_addr_i  = 32'h2000_2000;
      bus_wdata_i = 32'hFFFF_FFFF;
      bus_be_i    = 4'hF;
      #1;
      checks++;
      if (bus_gnt_o !== 1'b1 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bus_miss_req actual gnt=%b mreq=%b mwe=%b required 1/0/0",
                  bus_gnt_o, mem_req_o, mem_we_o);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus_rvalid_o !== 1'b1 || bus_err_o !== 1'b1 || bus_rdata_o !== 32'd0 || core_rvalid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bus_miss_rsp actual rvalid=%b err=%b rdata=%h corerv=%b required 1/1/0/0",
                  bus_rvalid_o, bus_err_o, bus_rdata_o, core_rvalid_o);
      end
      tick();
   endtask

   task automatic test_bus_write();
      bus_req_i   = 1'b1;
      bus_we_i    = 1'b1;
      bus_addr_i  = 32'h2000_0004;
      bus_wdata_i = 32'h1234_5678;
      bus_be_i    = 4'b0011;
      #1;
      checks++;
      if (bus_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 ||
          mem_addr_o !== 11'd1 || mem_wdata_o !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL bus_write_req actual gnt=%b mreq=%b mwe=%b be=%b maddr=%0d wdata=%h required 1/1/1/0011/1/12345678",
                  bus_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
      end
      tick();
      // Core read of the same word issued in the cycle the write response arrives
      bus_req_i   = 1'b0;
      bus_we_i    = 1'b0;
      core_req_i  = 1'b1;
      core_addr_i = 32'h2000_0004;
      #1;
      checks++;
      if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 32'd0 || bus_err_o !== 1'b0 || core_gnt_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bus_write_rsp actual rvalid=%b rdata=%h err=%b coregnt=%b required 1/0/0/1",
                  bus_rvalid_o, bus_rdata_o, bus_err_o, core_gnt_o);
      end
      tick();
      // Bus read of word 8 starts while the core response is returned
      core_req_i = 1'b0;
      bus_req_i  = 1'b1;
      bus_addr_i = 32'h2000_0020;
      #1;
      checks++;
      if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'hAABB_5678 || bus_rvalid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL core_readback actual rvalid=%b rdata=%h busrv=%b required 1/aabb5678/0",
                  core_rvalid_o, core_rdata_o, bus_rvalid_o);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 32'hDEAD_BEEF || bus_err_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bus_read_rsp actual rvalid=%b rdata=%h err=%b required 1/deadbeef/0",
                  bus_rvalid_o, bus_rdata_o, bus_err_o);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         core_req_i  = (i < 3);
         core_addr_i = 32'h2000_0008 + 32'(i * 4);
         #1;
         if (i > 0) begin
            checks++;
            if (core_rvalid_o !== 1'b1 || core_rdata_o !== (32'hC0DE_0000 | 32'(i + 1))) begin
               errors++;
               $display("[TB] FAIL back_to_back_%0d actual rvalid=%b rdata=%h required 1/%h",
                        i, core_rvalid_o, core_rdata_o, 32'hC0DE_0000 | 32'(i + 1));
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_fairness();
      bit prevBus;
      bit expBus;
      int coreWins = 0;
      int busWins  = 0;
      core_req_i  = 1'b1;
      core_addr_i = 32'h2000_0040;
      bus_req_i   = 1'b1;
      bus_we_i    = 1'b0;
      bus_addr_i  = 32'h2000_0080;
      prevBus     = 1'b0;
      for (int i = 0; i < 11; i++) begin
         #1;
         if (i > 0) begin
            checks++;
            if (prevBus ? (bus_rvalid_o !== 1'b1 || bus_rdata_o !== 32'hC0DE_0020 || core_rvalid_o !== 1'b0)
                        : (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'hC0DE_0010 || bus_rvalid_o !== 1'b0)) begin
               errors++;
               $display("[TB] FAIL contention_rsp_%0d actual corerv=%b crdata=%h busrv=%b brdata=%h required owner=%s",
                        i, core_rvalid_o, core_rdata_o, bus_rvalid_o, bus_rdata_o, prevBus ? "bus" : "core");
            end
         end
         if (i == 10) begin
            idle();
            break;
         end
`ifdef INST_ARB_FAIRNESS_EN
         expBus = (i % 5 == 4);
`else
         expBus = 1'b0;
`endif
         checks++;
         if (core_gnt_o !== !expBus || bus_gnt_o !== expBus) begin
            errors++;
            $display("[TB] FAIL contention_gnt_%0d actual core=%b bus=%b required core=%b bus=%b",
                     i, core_gnt_o, bus_gnt_o, !expBus, expBus);
         end
         if (core_gnt_o === 1'b1) coreWins++;
         if (bus_gnt_o === 1'b1) busWins++;
         prevBus = expBus;
         tick();
      end
`ifdef INST_ARB_FAIRNESS_EN
      checks++;
      if (coreWins != 8 || busWins != 2) begin
         errors++;
         $display("[TB] FAIL contention_totals actual core=%0d bus=%0d required core=8 bus=2", coreWins, busWins);
      end
`else
      checks++;
      if (coreWins != 10 || busWins != 0) begin
         errors++;
         $display("[TB] FAIL contention_totals actual core=%0d bus=%0d required core=10 bus=0", coreWins, busWins);
      end
`endif
      tick();
   endtask

   task automatic test_reset_drop();
      core_req_i  = 1'b1;
      core_addr_i = 32'h2000_0020;
      #1;
      checks++;
      if (core_gnt_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_drop_gnt actual gnt=%b required 1", core_gnt_o);
      end
      reset_ni = 1'b0;
      tick();
      core_req_i = 1'b0;
      reset_ni   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (core_rvalid_o !== 1'b0 || core_rdata_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_drop_rsp_%0d actual rvalid=%b rdata=%h required 0/0",
                     i, core_rvalid_o, core_rdata_o);
         end
         tick();
      end
   endtask

   // Run each scenario in order, then report
   initial begin
      test_reset();
      test_core_read();
      test_miss();
      test_bus_write();
      test_back_to_back();
      test_fairness();
      test_reset_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
